// File: rtl/bridge_pkg.sv
// Types local to the RAM-to-bus read/write bridge.
package bridge_pkg;

  typedef enum logic {
    IDLE,
    WAIT_RESP
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    SLV_ERR,
    TIMEOUT
  } err_cause_t;

endpackage

// File: rtl/bus_pkg.sv
// Shared system-bus command and response codes (OCP-like encoding).
package bus_pkg;

  typedef enum logic [2:0] {
    CMD_IDLE = 3'd0,
    CMD_WR   = 3'd1,
    CMD_RD   = 3'd2
  } mcmd_t;

  typedef enum logic [1:0] {
    RESP_NULL = 2'b00,
    RESP_DVA  = 2'b01,
    RESP_ERR  = 2'b11
  } sresp_t;

endpackage

// File: rtl/bus_if.sv
// OCP-like system bus with single-beat commands and responses.
interface Bus_if
  import bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  mcmd_t                 MCmd;
  logic [ADDR_W-1:0]     MAddr;
  logic [DATA_W-1:0]     MData;
  logic                  MDataValid;
  logic [DATA_W/8-1:0]   MByteEn;
  logic                  MRespAccept;
  logic                  MReset_n;
  logic                  SCmdAccept;
  sresp_t                SResp;
  logic [DATA_W-1:0]     SData;

  modport master (output MCmd, MAddr, MData, MDataValid, MByteEn, MRespAccept, MReset_n,
                  input  SCmdAccept, SResp, SData);
  modport slave  (input  MCmd, MAddr, MData, MDataValid, MByteEn, MRespAccept, MReset_n,
                  output SCmdAccept, SResp, SData);
endinterface

// File: rtl/ram_if.sv
// Stalling RAM-style core port; the bridge sits on the memory side.
interface Ram_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  en;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W/8-1:0]   be;
  logic [DATA_W-1:0]     data_w;
  logic [DATA_W-1:0]     data_r;
  logic                  delay;

  modport memory (input en, we, addr, be, data_w, output data_r, delay);
  modport core   (output en, we, addr, be, data_w, input data_r, delay);
endinterface

// File: rtl/bridge_timeout.sv
// Saturating response-wait counter; o_expire flags the last allowed cycle.
module bridge_timeout #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (TIMEOUT_CYCLES > 0) && (r_cnt == LAST);

endmodule

// File: rtl/bridge_ram2bus_rw.sv
// Read/write bridge from the stalling RAM port to the bus, with posted
// writes, back-to-back issue, slave-error handling and a response watchdog.
module bridge_ram2bus_rw
  import bridge_pkg::*;
  import bus_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int POSTED_WRITES  = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset,
  Ram_if.memory             ram,
  Bus_if.master             bus,
  input  logic              err_clr,
  output logic              err,
  output logic              err_timeout,
  output logic [ADDR_W-1:0] err_addr
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pend_addr;
  logic              r_err;
  logic              r_err_to;
  logic [ADDR_W-1:0] r_err_addr;

  logic       w_wait, w_dva, w_serr, w_expire, w_done;
  logic       w_issue, w_acc, w_enter;
  err_cause_t w_cause;

  assign w_wait  = (r_state == WAIT_RESP);
  assign w_dva   = w_wait && (bus.SResp == RESP_DVA);
  assign w_serr  = w_wait && (bus.SResp == RESP_ERR);
  assign w_done  = w_dva || w_serr || (w_wait && w_expire);
  assign w_issue = ram.en && !reset && (!w_wait || w_done);
  assign w_acc   = w_issue && bus.SCmdAccept;
  assign w_enter = w_acc && (!ram.we || (POSTED_WRITES == 0));

  always_comb begin
    w_cause = NONE;
    if (w_done && !w_dva) begin
      w_cause = w_serr ? SLV_ERR : TIMEOUT;
    end
  end

  bridge_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (!w_wait || w_enter),
    .i_en     (w_wait),
    .o_expire (w_expire)
  );

  assign bus.MReset_n    = ~reset;
  assign bus.MRespAccept = 1'b1;
  assign bus.MAddr       = ram.addr;
  assign bus.MByteEn     = ram.be;
  assign bus.MCmd        = !w_issue ? CMD_IDLE : (ram.we ? CMD_WR : CMD_RD);
  assign bus.MDataValid  = w_issue && ram.we;
  assign bus.MData       = bus.MDataValid ? ram.data_w : '0;

  // A refused command at done_now is already covered by the issue-not-accepted term.
  assign ram.delay  = !reset && ((w_wait && !w_done) || (w_issue && !bus.SCmdAccept));
  assign ram.data_r = (w_dva && !reset) ? bus.SData : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pend_addr <= '0;
      r_err       <= 1'b0;
      r_err_to    <= 1'b0;
      r_err_addr  <= '0;
    end else begin
      if (w_enter) begin
        r_state     <= WAIT_RESP;
        r_pend_addr <= ram.addr;
      end else if (w_done) begin
        r_state <= IDLE;
      end
      // A fresh error beats a simultaneous clear.
      if ((w_cause != NONE) && (!r_err || err_clr)) begin
        r_err      <= 1'b1;
        r_err_to   <= (w_cause == TIMEOUT);
        r_err_addr <= r_pend_addr;
      end else if (err_clr) begin
        r_err      <= 1'b0;
        r_err_to   <= 1'b0;
        r_err_addr <= '0;
      end
    end
  end

  assign err         = r_err;
  assign err_timeout = r_err_to;
  assign err_addr    = r_err_addr;

endmodule

// File: tb/tb_bridge_ram2bus_rw.sv
// Randomized bench: a posted-write/short-timeout bridge and a non-posted one
// share core stimulus, each checked against a transaction-level model.
module tb_bridge_ram2bus_rw;
  import bus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        err_clr;
  logic        e_err [2];
  logic        e_to  [2];
  logic [31:0] e_addr[2];

  Ram_if ram0 ();
  Ram_if ram1 ();
  Bus_if bus0 ();
  Bus_if bus1 ();

  bridge_ram2bus_rw #(.ADDR_W(32), .POSTED_WRITES(1), .TIMEOUT_CYCLES(4)) dut0 (
    .clk(clk), .reset(reset), .ram(ram0), .bus(bus0), .err_clr(err_clr),
    .err(e_err[0]), .err_timeout(e_to[0]), .err_addr(e_addr[0]));

  bridge_ram2bus_rw #(.ADDR_W(32), .POSTED_WRITES(0), .TIMEOUT_CYCLES(6)) dut1 (
    .clk(clk), .reset(reset), .ram(ram1), .bus(bus1), .err_clr(err_clr),
    .err(e_err[1]), .err_timeout(e_to[1]), .err_addr(e_addr[1]));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Model view: one outstanding transaction at most, aged in cycles.
  typedef struct {
    bit          busy;
    int          age;
    logic [31:0] pend;
    bit          err;
    bit          to;
    logic [31:0] eaddr;
  } mdl_t;
  mdl_t m[2];

  logic        s_en, s_we;
  logic [31:0] s_addr, s_dw;
  logic [3:0]  s_be;
  logic        s_acc [2];
  sresp_t      s_resp[2];
  logic [31:0] s_sd  [2];

  task automatic model_step(
    input int k, input bit posted, input int tmo,
    input mcmd_t cmd, input logic [31:0] mdata, input logic mdv,
    input logic [31:0] maddr, input logic [3:0] mbe, input logic mra, input logic mrn,
    input logic dly, input logic [31:0] dr,
    input logic err, input logic eto, input logic [31:0] ea);
    bit    ok, se, hit, fin, go;
    mcmd_t x_cmd;
    logic  x_dly;
    string p;
    p   = $sformatf("d%0d_", k);
    ok  = m[k].busy && (s_resp[k] == RESP_DVA);
    se  = m[k].busy && (s_resp[k] == RESP_ERR);
    hit = m[k].busy && (tmo > 0) && (m[k].age == tmo - 1);
    fin = ok || se || hit;
    go  = s_en && !reset && (!m[k].busy || fin);
    x_cmd = !go ? CMD_IDLE : (s_we ? CMD_WR : CMD_RD);
    x_dly = !reset && ((m[k].busy && !fin) || (go && !s_acc[k]));

    check({p, "mcmd"},    32'(cmd),  32'(x_cmd));
    check({p, "mdv"},     32'(mdv),  32'(go && s_we));
    check({p, "mdata"},   mdata,     (go && s_we) ? s_dw : 32'h0);
    check({p, "maddr"},   maddr,     s_addr);
    check({p, "mbe"},     32'(mbe),  32'(s_be));
    check({p, "mra"},     32'(mra),  32'h1);
    check({p, "mrst_n"},  32'(mrn),  32'(!reset));
    check({p, "delay"},   32'(dly),  32'(x_dly));
    check({p, "data_r"},  dr,        (ok && !reset) ? s_sd[k] : 32'h0);
    check({p, "err"},     32'(err),  32'(m[k].err));
    check({p, "err_to"},  32'(eto),  32'(m[k].to));
    check({p, "err_addr"}, ea,       m[k].eaddr);

    if (reset) begin
      m[k].busy = 0; m[k].age = 0; m[k].pend = '0;
      m[k].err = 0;  m[k].to = 0;  m[k].eaddr = '0;
    end else begin
      if (fin && !ok && (!m[k].err || err_clr)) begin
        m[k].err = 1; m[k].to = !se; m[k].eaddr = m[k].pend;
      end else if (err_clr) begin
        m[k].err = 0; m[k].to = 0; m[k].eaddr = '0;
      end
      if (go && s_acc[k] && (!s_we || !posted)) begin
        m[k].busy = 1; m[k].age = 0; m[k].pend = s_addr;
      end else if (fin) begin
        m[k].busy = 0;
      end else if (m[k].busy) begin
        m[k].age++;
      end
    end
  endtask

  task automatic drive();
    ram0.en = s_en; ram0.we = s_we; ram0.addr = s_addr; ram0.be = s_be; ram0.data_w = s_dw;
    ram1.en = s_en; ram1.we = s_we; ram1.addr = s_addr; ram1.be = s_be; ram1.data_w = s_dw;
    bus0.SCmdAccept = s_acc[0]; bus0.SResp = s_resp[0]; bus0.SData = s_sd[0];
    bus1.SCmdAccept = s_acc[1]; bus1.SResp = s_resp[1]; bus1.SData = s_sd[1];
  endtask

  initial begin
    reset = 1'b1; err_clr = 1'b0;
    s_en = 0; s_we = 0; s_addr = '0; s_dw = '0; s_be = '0;
    for (int k = 0; k < 2; k++) begin
      s_acc[k] = 0; s_resp[k] = RESP_NULL; s_sd[k] = '0;
      m[k].busy = 0; m[k].age = 0; m[k].pend = '0;
      m[k].err = 0;  m[k].to = 0;  m[k].eaddr = '0;
    end
    drive();
    @(posedge clk);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset   = (i < 2) || ($urandom_range(99) < 2);
      err_clr = ($urandom_range(99) < 6);
      s_en    = ($urandom_range(3) != 0);
      s_we    = $urandom_range(1) == 1;
      s_addr  = {24'h0, 6'($urandom_range(63)), 2'b00};
      s_be    = 4'($urandom_range(15));
      s_dw    = $urandom;
      for (int k = 0; k < 2; k++) begin
        int r;
        s_acc[k] = ($urandom_range(99) < 60);
        r = $urandom_range(99);
        s_resp[k] = (r < 70) ? RESP_NULL : (r < 88) ? RESP_DVA : RESP_ERR;
        s_sd[k] = $urandom;
      end
      drive();
      #1;
      model_step(0, 1'b1, 4, bus0.MCmd, bus0.MData, bus0.MDataValid, bus0.MAddr, bus0.MByteEn,
                 bus0.MRespAccept, bus0.MReset_n, ram0.delay, ram0.data_r,
                 e_err[0], e_to[0], e_addr[0]);
      model_step(1, 1'b0, 6, bus1.MCmd, bus1.MData, bus1.MDataValid, bus1.MAddr, bus1.MByteEn,
                 bus1.MRespAccept, bus1.MReset_n, ram1.delay, ram1.data_r,
                 e_err[1], e_to[1], e_addr[1]);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
